// File: rtl/grammer_pkg.sv
// Shared definitions for the grammer array reader: default sizes, FSM states
// and the overflow counter ceiling.
package grammer_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] OVF_MAX = 8'hFF;
endpackage

// File: rtl/grammer_entry_bank.sv
// Result bank filled by the array writer: one data word and one valid bit per
// entry, with clear-on-load, bulk flush and an overwrite-of-pending indication.
module grammer_entry_bank
    import grammer_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_idx,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic [DEPTH-1:0]  valid,
    output logic              ovf_pulse
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_nxt;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[ld_idx];

    // A write lands after the flush/load clear, so it always leaves its entry valid.
    always_comb begin
        valid_nxt = valid;
        if (flush) begin
            valid_nxt = '0;
        end else if (ld_en) begin
            valid_nxt[ld_idx] = 1'b0;
        end
        if (wr_en) begin
            valid_nxt[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            valid <= valid_nxt;
        end
    end

    // Overwriting the entry being loaded on the same edge hands the old word out, so nothing is lost.
    assign ovf_pulse = wr_en && valid[wr_addr] && !flush &&
                       !(ld_en && (ld_idx == wr_addr));
endmodule

// File: rtl/grammer_array_reader.sv
// Drains the result bank in strict address order over a valid/ready stream,
// keeping a running checksum of delivered words and a lost-result counter.
module grammer_array_reader
    import grammer_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic              clr_sum,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out1,
    output logic [DEPTH-1:0]  pending,
    output logic [7:0]        ovf_cnt
);
    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              ld_en;
    logic              hs;
    logic              ovf_pulse;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == OVF_MAX) ? OVF_MAX : v + 8'd1;
    endfunction

    assign ld_en = (state == IDLE) && pending[rd_ptr] && !flush;
    assign hs    = (state == HOLD) && out_valid && out_ready && !flush;

    grammer_entry_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ld_en     (ld_en),
        .ld_idx    (rd_ptr),
        .flush     (flush),
        .rd_data   (rd_data),
        .valid     (pending),
        .ovf_pulse (ovf_pulse)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            out       <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            out1      <= '0;
            ovf_cnt   <= '0;
        end else begin
            if (ovf_pulse) begin
                ovf_cnt <= sat_inc(ovf_cnt);
            end

            // The word handed over on a clearing edge becomes the first term of the new sum.
            if (clr_sum) begin
                out1 <= hs ? out : '0;
            end else if (hs) begin
                out1 <= out1 + out;
            end

            if (flush) begin
                state     <= IDLE;
                rd_ptr    <= '0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ld_en) begin
                            out       <= rd_data;
                            out_addr  <= rd_ptr;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (hs) begin
                            rd_ptr    <= rd_ptr + ADDR_W'(1);
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_grammer_array_reader.sv
// Bench for grammer_array_reader: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the bank and the stream.
module tb_grammer_array_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        flush = 1'b0;
    logic        clr_sum = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic [1:0]  out_addr;
    logic        out_valid;
    logic [31:0] out1;
    logic [3:0]  pending;
    logic [7:0]  ovf_cnt;

    int total = 0;
    int bad = 0;

    // Reference model: stored words, pending flags, next address to deliver,
    // the word currently offered, checksum and lost-result count.
    logic [31:0] mdata [4];
    logic [3:0]  mvalid;
    int          mptr;
    logic        held;
    logic [31:0] hout;
    logic [1:0]  haddr;
    logic [31:0] msum;
    int          movf;

    logic [31:0] saved;

    grammer_array_reader #(.DATA_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flush     (flush),
        .clr_sum   (clr_sum),
        .out_ready (out_ready),
        .out       (out),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out1      (out1),
        .pending   (pending),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mvalid = '0;
        mptr   = 0;
        held   = 1'b0;
        hout   = '0;
        haddr  = '0;
        msum   = '0;
        movf   = 0;
    endtask

    task automatic model_step(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                              input logic fl, input logic cs, input logic rdy);
        logic hs, cap;
        hs  = held && rdy && !fl;
        cap = !held && mvalid[mptr] && !fl;
        if (we && mvalid[wa] && !fl && !(cap && (int'(wa) == mptr)))
            movf = (movf >= 255) ? 255 : movf + 1;
        if (cs)
            msum = hs ? hout : 32'h0;
        else if (hs)
            msum = msum + hout;
        if (fl) begin
            mvalid = '0;
            mptr   = 0;
            held   = 1'b0;
        end else if (hs) begin
            held = 1'b0;
            mptr = (mptr + 1) % 4;
        end else if (cap) begin
            held  = 1'b1;
            hout  = mdata[mptr];
            haddr = 2'(mptr);
            mvalid[mptr] = 1'b0;
        end
        if (we) begin
            mdata[wa]  = wd;
            mvalid[wa] = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("out_valid", {31'b0, out_valid}, {31'b0, held});
        if (held) begin
            chk("out", out, hout);
            chk("out_addr", {30'b0, out_addr}, {30'b0, haddr});
        end
        chk("pending", {28'b0, pending}, {28'b0, mvalid});
        chk("out1", out1, msum);
        chk("ovf_cnt", {24'b0, ovf_cnt}, 32'(movf));
    endtask

    task automatic step(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                        input logic fl, input logic cs, input logic rdy);
        @(negedge clk);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        flush     = fl;
        clr_sum   = cs;
        out_ready = rdy;
        @(posedge clk);
        model_step(we, wa, wd, fl, cs, rdy);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_out", out, 32'h0);
        chk("rst_out_addr", {30'b0, out_addr}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out1", out1, 32'h0);
        chk("rst_pending", {28'b0, pending}, 32'h0);
        chk("rst_ovf", {24'b0, ovf_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Single word, two-cycle latency
        step(1, 2'd0, 32'h11, 0, 0, 1);
        chk("t1_pend_after_wr", {28'b0, pending}, 32'h1);
        chk("t1_no_valid_yet", {31'b0, out_valid}, 32'h0);
        step(0, 2'd0, 32'h0, 0, 0, 1);
        chk("t1_out", out, 32'h11);
        chk("t1_addr", {30'b0, out_addr}, 32'h0);
        chk("t1_valid", {31'b0, out_valid}, 32'h1);
        chk("t1_pend", {28'b0, pending}, 32'h0);
        step(0, 2'd0, 32'h0, 0, 0, 1);
        chk("t1_sum", out1, 32'h11);

        // Reverse-order writes delivered in address order
        step(0, 2'd0, 32'h0, 1, 1, 0);
        step(1, 2'd3, 32'h4, 0, 0, 1);
        step(1, 2'd2, 32'h3, 0, 0, 1);
        step(1, 2'd1, 32'h2, 0, 0, 1);
        step(1, 2'd0, 32'h1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 2'd0, 32'h0, 0, 0, 1);
            chk("t2_order_data", out, 32'(i + 1));
            chk("t2_order_addr", {30'b0, out_addr}, 32'(i));
            step(0, 2'd0, 32'h0, 0, 0, 1);
        end
        chk("t2_sum", out1, 32'hA);

        // Overwrite of a pending entry, then saturation
        step(1, 2'd1, 32'h5, 0, 0, 0);
        step(1, 2'd1, 32'h6, 0, 0, 0);
        chk("t3_ovf1", {24'b0, ovf_cnt}, 32'h1);
        step(1, 2'd0, 32'h20, 0, 0, 1);
        step(0, 2'd0, 32'h0, 0, 0, 1);
        step(0, 2'd0, 32'h0, 0, 0, 1);
        step(0, 2'd0, 32'h0, 0, 0, 1);
        chk("t3_latest_data", out, 32'h6);
        chk("t3_latest_addr", {30'b0, out_addr}, 32'h1);
        step(0, 2'd0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 300; i++)
            step(1, 2'd3, 32'(i), 0, 0, 0);
        chk("t3_ovf_sat", {24'b0, ovf_cnt}, 32'hFF);
        step(0, 2'd0, 32'h0, 1, 0, 0);
        chk("t3_ovf_kept", {24'b0, ovf_cnt}, 32'hFF);

        // Backpressure keeps the offered word stable
        saved = msum;
        step(1, 2'd0, 32'hDEAD_BEEF, 0, 0, 0);
        step(0, 2'd0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 2'd0, 32'h0, 0, 0, 0);
            chk("t4_hold_out", out, 32'hDEAD_BEEF);
            chk("t4_hold_addr", {30'b0, out_addr}, 32'h0);
            chk("t4_hold_valid", {31'b0, out_valid}, 32'h1);
        end
        step(0, 2'd0, 32'h0, 0, 0, 1);
        chk("t4_sum", out1, saved + 32'hDEAD_BEEF);
        chk("t4_done", {31'b0, out_valid}, 32'h0);

        // Flush beats handshake; simultaneous write survives
        step(1, 2'd1, 32'h55, 0, 0, 0);
        step(0, 2'd0, 32'h0, 0, 0, 0);
        chk("t5_held", {31'b0, out_valid}, 32'h1);
        saved = out1;
        step(1, 2'd2, 32'h7, 1, 0, 1);
        chk("t5_valid", {31'b0, out_valid}, 32'h0);
        chk("t5_sum", out1, saved);
        chk("t5_pend", {28'b0, pending}, 32'h4);
        step(1, 2'd0, 32'h8, 0, 0, 0);
        step(0, 2'd0, 32'h0, 0, 0, 0);
        chk("t5_ptr0_addr", {30'b0, out_addr}, 32'h0);
        chk("t5_ptr0_data", out, 32'h8);

        // Checksum restart coinciding with a handshake
        step(0, 2'd0, 32'h0, 1, 0, 0);
        step(0, 2'd0, 32'h0, 0, 1, 0);
        chk("t6_cleared", out1, 32'h0);
        step(1, 2'd0, 32'h100, 0, 0, 1);
        step(0, 2'd0, 32'h0, 0, 0, 1);
        step(0, 2'd0, 32'h0, 0, 0, 1);
        chk("t6_sum100", out1, 32'h100);
        step(1, 2'd1, 32'h9, 0, 0, 0);
        step(0, 2'd0, 32'h0, 0, 0, 0);
        step(0, 2'd0, 32'h0, 0, 1, 1);
        chk("t6_restart", out1, 32'h9);

        // Asynchronous reset while a word is held
        step(1, 2'd2, 32'hABC, 0, 0, 0);
        step(0, 2'd0, 32'h0, 0, 0, 0);
        chk("t7_held", {31'b0, out_valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("t7_out", out, 32'h0);
        chk("t7_addr", {30'b0, out_addr}, 32'h0);
        chk("t7_valid", {31'b0, out_valid}, 32'h0);
        chk("t7_sum", out1, 32'h0);
        chk("t7_pend", {28'b0, pending}, 32'h0);
        chk("t7_ovf", {24'b0, ovf_cnt}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            logic fl, cs;
            fl = ($urandom_range(0, 31) == 0);
            cs = !fl && ($urandom_range(0, 19) == 0);
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                 fl, cs, ($urandom_range(0, 9) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
